stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control and timekeeping stage directly downstream of the button synchroniser/edge detectors.
- Consumes single-cycle, clock-synchronous button pulses (start/stop, clear). Runs a three-state FSM, divides the system clock to a 100 Hz tick, and maintains hundredths/seconds/minutes counts for the display stage.

Parameters:
- CLK_DIV, 100000, system clock cycles per hundredth-second tick (10 MHz -> 100 Hz); legal range >= 2; sims use 4.
- MAX_MIN, 99, highest minute value before wrap; legal range 1..127.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start_stop_pulse  input  1  one-cycle pulse from upstream edge detector; toggles run/stop.
- clear_pulse  input  1  one-cycle pulse from upstream edge detector; zeroes the time.
- running  output  1  high while the FSM is in RUNNING.
- centis  output  7  hundredths, 0..99.
- secs  output  6  seconds, 0..59.
- mins  output  7  minutes, 0..MAX_MIN.
- overflow  output  1  sticky; set on wrap past MAX_MIN:59:99.

Behaviour:
- Reset (rst high, asynchronous assert):
  - state=IDLE, prescaler=0, centis=secs=mins=0, overflow=0, running=0.
  - Effective immediately, including mid-run. Synchronous release; first transition possible on the first rising edge with rst low.
- All outputs are registered; no combinational paths from inputs to outputs.
- FSM states: IDLE, RUNNING, STOPPED. Transitions are evaluated per rising edge:
  - IDLE: start_stop_pulse -> RUNNING; clear_pulse -> stay IDLE (counts already 0; clears overflow).
  - RUNNING: start_stop_pulse -> STOPPED. clear_pulse ignored (no state or count change).
  - STOPPED: clear_pulse -> IDLE with prescaler and all counts zeroed, overflow cleared. start_stop_pulse (no clear) -> RUNNING, resuming from held counts and held prescaler value.
  - Simultaneous clear_pulse and start_stop_pulse: in STOPPED, clear wins and start is ignored. In IDLE, go RUNNING and treat clear as a no-op. In RUNNING, go STOPPED and ignore clear.
- running = 1 exactly in the cycles state==RUNNING; it changes on the same edge as the state.
- Prescaler:
  - Width $clog2(CLK_DIV); advances only while state==RUNNING.
  - When prescaler==CLK_DIV-1 it returns to 0 and an internal tick is asserted for that cycle; otherwise it increments.
  - Frozen in STOPPED; zeroed in IDLE.
- Tick latency and spacing:
  - First increment of centis occurs on the CLK_DIV-th rising edge after the edge that entered RUNNING from IDLE.
  - Subsequent increments are exactly CLK_DIV cycles apart.
- Counter cascade (on a tick):
  - centis increments; at 99 it wraps to 0 and carries to secs.
  - secs wraps at 59 and carries to mins.
  - mins wraps at MAX_MIN to 0; this wrap sets overflow=1.
  - Counting continues after wrap; overflow holds until clear or reset.
- A stop that coincides with a tick edge: the transition wins and the tick is not applied. Counts and prescaler freeze at their pre-edge values, so no partial time is lost or double-counted on resume.
- Pulses longer than one cycle are out of contract. Each high cycle is treated as a separate pulse; the bench checks that a two-cycle pulse in IDLE yields RUNNING then STOPPED.

Test Plan:
- Reset mid-run: CLK_DIV=4; run 30 cycles, assert rst for one cycle asynchronously between edges -> running=0, centis=secs=mins=0, overflow=0 immediately, before the next edge.
- Basic count: CLK_DIV=4; start pulse at edge 0 -> centis=1 after edge 4, 2 after edge 8, 25 after edge 100; running=1 throughout.
- Stop/resume/clear: stop after 10 cycles (centis=2, prescaler=2); idle 50 cycles -> outputs unchanged. Clear pulse while running -> ignored. Start -> centis=3 two edges later. Stop, then clear -> IDLE, all zero.
- Cascade: preload-free run with CLK_DIV=2, MAX_MIN=1 to 1:59:99 -> next tick gives 0:00:00 with overflow=1. Overflow remains 1 while counting continues, and clears on stop+clear.
- Simultaneous pulses: in STOPPED at 0:00:05, assert both pulses in one cycle -> IDLE, counts 0, running=0. In IDLE, assert both -> RUNNING.
- Stop on tick edge: CLK_DIV=4; start, assert stop in the cycle where prescaler=3 -> centis stays 0 and prescaler stays 3. Restart -> centis=1 exactly one edge later.

Source files
------------

// File: rtl/stopwatch_if.sv
// stopwatch_if: button pulses in, run state and time counts out.
interface stopwatch_if;
    logic       start_stop_pulse;
    logic       clear_pulse;
    logic       running;
    logic [6:0] centis;
    logic [5:0] secs;
    logic [6:0] mins;
    logic       overflow;
    modport master (output start_stop_pulse, clear_pulse, input running, centis, secs, mins, overflow);
    modport slave (input start_stop_pulse, clear_pulse, output running, centis, secs, mins, overflow);
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/clear FSM with a CLK_DIV prescaler feeding a
// centis/secs/mins cascade; sticky overflow on wrap past MAX_MIN:59:99.
module stopwatch_ctrl #(
    parameter int CLK_DIV = 100000,
    parameter int MAX_MIN = 99
) (
    input logic        clk,
    input logic        rst,
    stopwatch_if.slave sw
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    typedef enum logic [1:0] {IDLE, RUNNING, STOPPED} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [6:0]    centis_q, centis_d, mins_q, mins_d;
    logic [5:0]    secs_q, secs_d;
    logic          overflow_q, overflow_d, running_q, running_d;
    logic          tick;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            centis_q   <= '0;
            secs_q     <= '0;
            mins_q     <= '0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            centis_q   <= centis_d;
            secs_q     <= secs_d;
            mins_q     <= mins_d;
            overflow_q <= overflow_d;
            running_q  <= running_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        centis_d   = centis_q;
        secs_d     = secs_q;
        mins_d     = mins_q;
        overflow_d = overflow_q;
        tick       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sw.start_stop_pulse) state_d = RUNNING;
                else if (sw.clear_pulse) overflow_d = 1'b0;
            end
            RUNNING: begin
                // a stop on a tick edge freezes everything at pre-edge values
                if (sw.start_stop_pulse) state_d = STOPPED;
                else begin
                    tick  = pre_q == PRE_MAX;
                    pre_d = tick ? '0 : pre_q + 1'b1;
                end
            end
            STOPPED: begin
                if (sw.clear_pulse) begin
                    state_d    = IDLE;
                    pre_d      = '0;
                    centis_d   = '0;
                    secs_d     = '0;
                    mins_d     = '0;
                    overflow_d = 1'b0;
                end else if (sw.start_stop_pulse) state_d = RUNNING;
            end
            default: state_d = IDLE;
        endcase
        if (tick) begin
            centis_d = centis_q == 7'd99 ? '0 : centis_q + 7'd1;
            if (centis_q == 7'd99) secs_d = secs_q == 6'd59 ? '0 : secs_q + 6'd1;
            if (centis_q == 7'd99 && secs_q == 6'd59) begin
                mins_d     = mins_q == 7'(MAX_MIN) ? '0 : mins_q + 7'd1;
                overflow_d = overflow_q | (mins_q == 7'(MAX_MIN));
            end
        end
        running_d = state_d == RUNNING;
    end
    assign sw.running  = running_q;
    assign sw.centis   = centis_q;
    assign sw.secs     = secs_q;
    assign sw.mins     = mins_q;
    assign sw.overflow = overflow_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed steps against two instances (CLK_DIV=4/MAX_MIN=99
// and CLK_DIV=2/MAX_MIN=1), expected outputs queued then popped at each check.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    stopwatch_if ia ();
    stopwatch_if ib ();
    stopwatch_ctrl #(.CLK_DIV(4), .MAX_MIN(99)) dut_a (.clk(clk), .rst(rst), .sw(ia.slave));
    stopwatch_ctrl #(.CLK_DIV(2), .MAX_MIN(1)) dut_b (.clk(clk), .rst(rst), .sw(ib.slave));
    typedef struct {
        string       tag;
        bit          dut;
        logic [21:0] v;
    } exp_t;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse_a(input logic ss, input logic clr);
        ia.start_stop_pulse = ss;
        ia.clear_pulse      = clr;
        cyc(1);
        ia.start_stop_pulse = 1'b0;
        ia.clear_pulse      = 1'b0;
    endtask
    task automatic pulse_b(input logic ss, input logic clr);
        ib.start_stop_pulse = ss;
        ib.clear_pulse      = clr;
        cyc(1);
        ib.start_stop_pulse = 1'b0;
        ib.clear_pulse      = 1'b0;
    endtask
    task automatic expect_out(input string tag, input bit d, input logic r, input int c,
                              input int s, input int m, input logic o);
        exp_t e;
        e.tag = tag;
        e.dut = d;
        e.v   = {r, 7'(c), 6'(s), 7'(m), o};
        sb.push_back(e);
    endtask
    task automatic check();
        exp_t e;
        logic [21:0] obs;
        e   = sb.pop_front();
        obs = e.dut ? {ib.running, ib.centis, ib.secs, ib.mins, ib.overflow}
                    : {ia.running, ia.centis, ia.secs, ia.mins, ia.overflow};
        tests++;
        assert (obs === e.v) else begin
            fails++;
            $error("FAIL %s: observed {run,c,s,m,ovf}=%h expected %h", e.tag, obs, e.v);
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        ia.start_stop_pulse = 1'b0;
        ia.clear_pulse      = 1'b0;
        ib.start_stop_pulse = 1'b0;
        ib.clear_pulse      = 1'b0;
        cyc(2);
        expect_out("reset_a", 0, 0, 0, 0, 0, 0); check();
        expect_out("reset_b", 1, 0, 0, 0, 0, 0); check();
        rst = 1'b0;
        expect_out("start", 0, 1, 0, 0, 0, 0); pulse_a(1, 0); check();
        expect_out("count_e4", 0, 1, 1, 0, 0, 0); cyc(4); check();
        expect_out("count_e8", 0, 1, 2, 0, 0, 0); cyc(4); check();
        expect_out("count_e100", 0, 1, 25, 0, 0, 0); cyc(92); check();
        #2 rst = 1'b1;
        #1 expect_out("async_reset", 0, 0, 0, 0, 0, 0); check();
        rst = 1'b0;
        expect_out("after_reset_edge", 0, 0, 0, 0, 0, 0); cyc(1); check();
        pulse_a(1, 0);
        cyc(10);
        expect_out("stop_c2", 0, 0, 2, 0, 0, 0); pulse_a(1, 0); check();
        expect_out("stopped_hold", 0, 0, 2, 0, 0, 0); cyc(50); check();
        expect_out("resume", 0, 1, 2, 0, 0, 0); pulse_a(1, 0); check();
        expect_out("clear_running_ign", 0, 1, 2, 0, 0, 0); pulse_a(0, 1); check();
        expect_out("resume_c3", 0, 1, 3, 0, 0, 0); cyc(1); check();
        expect_out("stop_c3", 0, 0, 3, 0, 0, 0); pulse_a(1, 0); check();
        expect_out("clear_idle", 0, 0, 0, 0, 0, 0); pulse_a(0, 1); check();
        pulse_a(1, 0);
        expect_out("run_c5", 0, 1, 5, 0, 0, 0); cyc(20); check();
        expect_out("stop_c5", 0, 0, 5, 0, 0, 0); pulse_a(1, 0); check();
        expect_out("both_stopped", 0, 0, 0, 0, 0, 0); pulse_a(1, 1); check();
        expect_out("both_idle", 0, 1, 0, 0, 0, 0); pulse_a(1, 1); check();
        expect_out("pre_zeroed_e4", 0, 1, 1, 0, 0, 0); cyc(4); check();
        pulse_a(1, 0);
        pulse_a(0, 1);
        pulse_a(1, 0);
        cyc(3);
        expect_out("stop_on_tick", 0, 0, 0, 0, 0, 0); pulse_a(1, 0); check();
        expect_out("restart_no_tick", 0, 1, 0, 0, 0, 0); pulse_a(1, 0); check();
        expect_out("restart_tick_1edge", 0, 1, 1, 0, 0, 0); cyc(1); check();
        pulse_a(1, 0);
        pulse_a(0, 1);
        ia.start_stop_pulse = 1'b1;
        expect_out("long_pulse_run", 0, 1, 0, 0, 0, 0); cyc(1); check();
        expect_out("long_pulse_stop", 0, 0, 0, 0, 0, 0); cyc(1); check();
        ia.start_stop_pulse = 1'b0;
        pulse_b(1, 0);
        expect_out("casc_1_59_99", 1, 1, 99, 59, 1, 0); cyc(23998); check();
        expect_out("casc_wrap_ovf", 1, 1, 0, 0, 0, 1); cyc(2); check();
        expect_out("ovf_sticky", 1, 1, 0, 1, 0, 1); cyc(200); check();
        pulse_b(1, 0);
        expect_out("ovf_cleared", 1, 0, 0, 0, 0, 0); pulse_b(0, 1); check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
